// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the execute/memory completion paths and the writeback
// arbiter. The arbiter is the slave side; the producer/consumer environment
// (or a testbench) is the master side.
interface wb_port_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  // ALU completion source
  logic                        alu_valid;
  logic                        alu_ready;
  logic [REG_ADDR_W-1:0]       alu_rd;
  logic [DATA_W-1:0]           alu_val;

  // Load completion source
  logic                        ld_valid;
  logic                        ld_ready;
  logic [REG_ADDR_W-1:0]       ld_rd;
  logic [DATA_W-1:0]           ld_val;

  // Register-file write port
  logic                        reg_write_en;
  logic [REG_ADDR_W-1:0]       reg_num;
  logic [DATA_W-1:0]           reg_val;
  logic                        grant_ld;

  // Status towards issue
  logic [(1<<REG_ADDR_W)-1:0]  pending_mask;
  logic                        proto_err;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output ld_valid, ld_rd, ld_val,
    input  alu_ready, ld_ready,
    input  reg_write_en, reg_num, reg_val, grant_ld,
    input  pending_mask, proto_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  ld_valid, ld_rd, ld_val,
    output alu_ready, ld_ready,
    output reg_write_en, reg_num, reg_val, grant_ld,
    output pending_mask, proto_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: the ALU and load completion paths each feed a small
// FIFO; one head is committed to the register-file write port per cycle.
// Load wins contention unless the ALU head has been starved for STARVE_LIMIT
// cycles. A pending-destination mask covers every buffered entry plus the
// write currently on the output register.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 4,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  wb_port_arbiter_if.slave bus
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam int PTR_W    = $clog2(BUF_DEPTH);
  localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(BUF_DEPTH);
  localparam logic [3:0]       STARVE_MAX = 4'(STARVE_LIMIT);

  // Source index 0 is the ALU path, index 1 the load path.
  logic [1:0]                        in_valid;
  logic [1:0][REG_ADDR_W-1:0]        in_rd;
  logic [1:0][DATA_W-1:0]            in_val;
  logic [1:0]                        push;
  logic [1:0]                        pop;
  logic [1:0]                        not_empty;
  logic [1:0]                        ready;
  logic [1:0][REG_ADDR_W-1:0]        head_rd;
  logic [1:0][DATA_W-1:0]            head_val;
  logic [1:0][NUM_REGS-1:0]          fifo_mask;

  logic                              grant_alu_c;
  logic                              grant_ld_c;
  logic [3:0]                        starve_q, starve_d;
  logic                              wen_q, wen_d;
  logic [REG_ADDR_W-1:0]             num_q, num_d;
  logic [DATA_W-1:0]                 val_q, val_d;
  logic                              gld_q, gld_d;
  logic                              perr_q, perr_d;
  logic [NUM_REGS-1:0]               out_mask;
  logic [NUM_REGS-1:0]               pend_c;

  assign in_valid = {bus.ld_valid, bus.alu_valid};
  assign in_rd    = {bus.ld_rd,    bus.alu_rd};
  assign in_val   = {bus.ld_val,   bus.alu_val};
  assign pop      = {grant_ld_c,   grant_alu_c};

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [REG_ADDR_W-1:0] rd_mem [BUF_DEPTH];
    logic [DATA_W-1:0]     val_mem [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [NUM_REGS-1:0]   mask_c;
    logic [PTR_W-1:0]      slot_c;

    // Ready is a flop of the post-edge count, so a full FIFO never accepts
    // in the same cycle it frees a slot.
    assign push[gi]      = in_valid[gi] & ready_q;
    assign ready[gi]     = ready_q;
    assign not_empty[gi] = (cnt_q != '0);
    assign head_rd[gi]   = rd_mem[rd_ptr_q];
    assign head_val[gi]  = val_mem[rd_ptr_q];
    assign fifo_mask[gi] = mask_c;

    // Entry storage; slots outside the live window are don't-care.
    always_ff @(posedge clk) begin
      if (push[gi]) begin
        rd_mem[wr_ptr_q]  <= in_rd[gi];
        val_mem[wr_ptr_q] <= in_val[gi];
      end
    end

    // Pointer and occupancy next-state; pointers wrap on the power-of-2 depth.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push[gi] && !pop[gi])      cnt_d = cnt_q + CNT_W'(1);
      else if (!push[gi] && pop[gi]) cnt_d = cnt_q - CNT_W'(1);
      ready_d = (cnt_d != FULL_CNT);
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ready_q  <= 1'b1;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        ready_q  <= ready_d;
      end
    end

    // One-hot destinations of every live entry, walking from the head.
    always_comb begin
      mask_c = '0;
      slot_c = '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        slot_c = rd_ptr_q + PTR_W'(i);
        if (CNT_W'(i) < cnt_q) mask_c[rd_mem[slot_c]] = 1'b1;
      end
    end
  end

  // Destination of the write currently presented to the register file.
  always_comb begin
    out_mask = '0;
    if (wen_q) out_mask[num_q] = 1'b1;
  end

  assign pend_c = fifo_mask[0] | fifo_mask[1] | out_mask;

  // Grant selection, starvation tracking, write-port and error next-state.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_ld_c  = 1'b0;
    if (not_empty[0] && (!not_empty[1] || starve_q == STARVE_MAX)) begin
      grant_alu_c = 1'b1;
    end else if (not_empty[1]) begin
      grant_ld_c = 1'b1;
    end

    // Only counts cycles where the ALU had a head and lost to the load path.
    starve_d = starve_q;
    if (!not_empty[0] || grant_alu_c) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end

    wen_d = grant_alu_c | grant_ld_c;
    num_d = num_q;
    val_d = val_q;
    gld_d = gld_q;
    if (grant_ld_c) begin
      num_d = head_rd[1];
      val_d = head_val[1];
      gld_d = 1'b1;
    end else if (grant_alu_c) begin
      num_d = head_rd[0];
      val_d = head_val[0];
      gld_d = 1'b0;
    end

    // Accepted pushes that collide with an in-flight write, or with each other.
    perr_d = perr_q;
    if (push[0] && pend_c[in_rd[0]]) perr_d = 1'b1;
    if (push[1] && pend_c[in_rd[1]]) perr_d = 1'b1;
    if (push[0] && push[1] && (in_rd[0] == in_rd[1])) perr_d = 1'b1;
  end

  // Arbiter and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      wen_q    <= 1'b0;
      num_q    <= '0;
      val_q    <= '0;
      gld_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wen_q    <= wen_d;
      num_q    <= num_d;
      val_q    <= val_d;
      gld_q    <= gld_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.alu_ready    = ready[0];
  assign bus.ld_ready     = ready[1];
  assign bus.reg_write_en = wen_q;
  assign bus.reg_num      = num_q;
  assign bus.reg_val      = val_q;
  assign bus.grant_ld     = gld_q;
  assign bus.pending_mask = pend_c;
  assign bus.proto_err    = perr_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a queue-level reference model predicts every
// register-file write; a negedge monitor pops and compares each write and
// checks readies, pending mask and the sticky error flag every cycle.
module tb_wb_port_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 3;
  localparam int NR    = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

  wb_port_arbiter #(
    .DATA_W(DW), .REG_ADDR_W(AW), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] val; } ent_t;
  typedef struct packed { logic [AW-1:0] rd; logic [DW-1:0] val; logic ld; } wr_t;

  ent_t aq[$];
  ent_t lq[$];
  wr_t  exp_q[$];
  int   starve;
  bit   m_wen;
  logic [AW-1:0] m_num;
  bit   m_perr;
  bit   started = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [NR-1:0] m_pend;
  bit   a_acc, l_acc;
  ent_t m_e;

  function automatic logic [NR-1:0] model_pending();
    logic [NR-1:0] m;
    m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (lq[i]) m[lq[i].rd] = 1'b1;
    if (m_wen) m[m_num] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference model: advances at each rising edge from the inputs presented.
  initial begin
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (rst) begin
        aq.delete(); lq.delete(); exp_q.delete();
        starve = 0; m_wen = 1'b0; m_num = '0; m_perr = 1'b0;
      end else begin
        m_pend = model_pending();
        a_acc  = bus.alu_valid && (aq.size() < DEPTH);
        l_acc  = bus.ld_valid  && (lq.size() < DEPTH);
        if ((a_acc && m_pend[bus.alu_rd]) || (l_acc && m_pend[bus.ld_rd]) ||
            (a_acc && l_acc && bus.alu_rd == bus.ld_rd)) m_perr = 1'b1;
        m_wen = 1'b0;
        if (aq.size() != 0 && (lq.size() == 0 || starve == LIMIT)) begin
          m_e = aq.pop_front();
          exp_q.push_back({m_e.rd, m_e.val, 1'b0});
          m_wen = 1'b1; m_num = m_e.rd; starve = 0;
        end else if (lq.size() != 0) begin
          m_e = lq.pop_front();
          exp_q.push_back({m_e.rd, m_e.val, 1'b1});
          m_wen = 1'b1; m_num = m_e.rd;
          starve = (aq.size() != 0) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        end else begin
          starve = 0;
        end
        if (a_acc) aq.push_back({bus.alu_rd, bus.alu_val});
        if (l_acc) lq.push_back({bus.ld_rd, bus.ld_val});
      end
    end
  end

  // Monitor: scoreboard pop on every write plus per-cycle status checks.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (started) begin
        check("write_en", 64'(bus.reg_write_en), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          if (bus.reg_write_en === 1'b1) begin
            $display("write rd=%0d val=%h src=%s", bus.reg_num, bus.reg_val,
                     bus.grant_ld ? "ld" : "alu");
            check("write_data", {27'd0, bus.reg_num, bus.reg_val, bus.grant_ld},
                  {27'd0, w.rd, w.val, w.ld});
          end
        end
        check("alu_ready", 64'(bus.alu_ready), 64'(aq.size() < DEPTH));
        check("ld_ready",  64'(bus.ld_ready),  64'(lq.size() < DEPTH));
        check("pending_mask", 64'(bus.pending_mask), 64'(model_pending()));
        check("proto_err", 64'(bus.proto_err), 64'(m_perr));
      end
    end
  end

  // Hold the offer until the registered ready shows it was taken.
  task automatic alu_push(input logic [AW-1:0] rd, input logic [DW-1:0] val);
    bit acc;
    int n;
    n = 0;
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_val = val;
    do begin
      acc = bus.alu_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      total++; bad++;
      $display("FAIL alu_push_timeout: got ready=0 want ready=1 within 64 cycles");
    end
  endtask

  task automatic ld_push(input logic [AW-1:0] rd, input logic [DW-1:0] val);
    bit acc;
    int n;
    n = 0;
    bus.ld_valid = 1'b1; bus.ld_rd = rd; bus.ld_val = val;
    do begin
      acc = bus.ld_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      total++; bad++;
      $display("FAIL ld_push_timeout: got ready=0 want ready=1 within 64 cycles");
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_val = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_val  = '0;
    repeat (3) @(negedge clk);
    check("rst_wen", 64'(bus.reg_write_en), 64'd0);
    check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
    check("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    check("rst_mask", 64'(bus.pending_mask), 64'd0);
    check("rst_perr", 64'(bus.proto_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single ALU write: two-cycle latency, destination pending until commit ends.
    alu_push(4'd3, 32'h1234);
    bus.alu_valid = 1'b0;
    check("t1_wen_early", 64'(bus.reg_write_en), 64'd0);
    check("t1_pend_buf", 64'(bus.pending_mask[3]), 64'd1);
    @(negedge clk);
    check("t1_wen", 64'(bus.reg_write_en), 64'd1);
    check("t1_num", 64'(bus.reg_num), 64'd3);
    check("t1_val", 64'(bus.reg_val), 64'h1234);
    check("t1_gld", 64'(bus.grant_ld), 64'd0);
    check("t1_pend_out", 64'(bus.pending_mask[3]), 64'd1);
    @(negedge clk);
    check("t1_pend_clr", 64'(bus.pending_mask[3]), 64'd0);
    repeat (2) @(negedge clk);

    // Simultaneous offers: load first, ALU the following cycle.
    bus.alu_valid = 1'b1; bus.alu_rd = 4'd1; bus.alu_val = 32'hA1A1_0001;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 4'd2; bus.ld_val  = 32'hB2B2_0002;
    @(negedge clk);
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    @(negedge clk);
    check("t2_first_gld", 64'(bus.grant_ld), 64'd1);
    check("t2_first_num", 64'(bus.reg_num), 64'd2);
    @(negedge clk);
    check("t2_second_gld", 64'(bus.grant_ld), 64'd0);
    check("t2_second_num", 64'(bus.reg_num), 64'd1);
    repeat (3) @(negedge clk);

    // Starvation: load stream against one ALU entry.
    fork
      begin
        alu_push(4'd7, 32'hA7A7_A7A7);
        bus.alu_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) ld_push(4'(8 + i), $urandom);
        bus.ld_valid = 1'b0;
      end
    join
    repeat (5) @(negedge clk);

    // Backpressure: three back-to-back ALU offers while loads keep winning.
    fork
      begin
        alu_push(4'd4, 32'h0000_0A04);
        alu_push(4'd5, 32'h0000_0A05);
        check("t4_alu_full", 64'(bus.alu_ready), 64'd0);
        alu_push(4'd6, 32'h0000_0A06);
        bus.alu_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) ld_push(4'(8 + i), $urandom);
        bus.ld_valid = 1'b0;
      end
    join
    repeat (6) @(negedge clk);

    // Same destination from both sources while pending: sticky error, both written.
    check("t5_perr_before", 64'(bus.proto_err), 64'd0);
    alu_push(4'd5, 32'h5555_0001);
    bus.alu_valid = 1'b0;
    ld_push(4'd5, 32'h5555_0002);
    bus.ld_valid = 1'b0;
    check("t5_perr_set", 64'(bus.proto_err), 64'd1);
    repeat (4) @(negedge clk);
    check("t5_perr_sticky", 64'(bus.proto_err), 64'd1);

    // Reset with both FIFOs busy: everything in flight is dropped.
    bus.alu_valid = 1'b1; bus.ld_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.alu_rd = 4'($urandom); bus.alu_val = $urandom;
      bus.ld_rd  = 4'($urandom); bus.ld_val  = $urandom;
      @(negedge clk);
    end
    check("t6_busy", 64'(!(bus.alu_ready && bus.ld_ready)), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    check("t6_wen", 64'(bus.reg_write_en), 64'd0);
    check("t6_mask", 64'(bus.pending_mask), 64'd0);
    check("t6_readies", {62'd0, bus.alu_ready, bus.ld_ready}, 64'd3);
    check("t6_perr", 64'(bus.proto_err), 64'd0);
    repeat (6) @(negedge clk);

    // Random traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = 4'($urandom);
      bus.alu_val   = $urandom;
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_rd     = 4'($urandom);
      bus.ld_val    = $urandom;
      rst           = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || aq.size() != 0 || lq.size() != 0 || m_wen) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_empty", 64'(aq.size() + lq.size() + exp_q.size()), 64'd0);
    check("drain_idle", 64'(bus.reg_write_en), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
